// File: rtl/i_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// i_ram_loader_pkg
//   Shared definitions for the instruction-image loaders (this loader, the bus
//   bridge and the debug loader):
//     - loader_state_t    : frame-parser state encoding
//     - DEFAULT_SYNC_BYTE : frame start marker
//     - ready_in_state()  : whether the byte source may hand over a byte while
//                           the parser sits in a given state (the FIN cycle
//                           refuses bytes so the outcome pulse settles first)
// -----------------------------------------------------------------------------
package i_ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_FIN     = 3'd6
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // rx_ready is a registered output, so callers evaluate this for the state
  // being entered, not the state being left.
  function automatic logic ready_in_state(input loader_state_t st);
    return (st != ST_FIN);
  endfunction

endpackage

// File: rtl/i_ram_loader.sv
// -----------------------------------------------------------------------------
// i_ram_loader
//   Receives a framed byte stream
//     sync, LEN_HI, LEN_LO, N x (data_hi, data_lo), CHK
//   packs data bytes big-endian into 16-bit words and writes them to the
//   instruction RAM from address 0. The core is held while a load is in
//   flight; a good load ends with a done pulse and releases the core, an
//   oversize length or bad checksum gives an error pulse and keeps it held.
//
// Parameters
//   addr_width : instruction RAM address width (image up to 1<<addr_width words)
//   sync_byte  : frame start marker
//
// Ports
//   clk       in   system clock, posedge
//   rst_n     in   asynchronous active-low reset
//   rx_data   in   incoming byte
//   rx_valid  in   rx_data valid
//   rx_ready  out  byte accepted when rx_valid & rx_ready
//   w_addr    out  RAM write address (held between writes)
//   din       out  RAM write data (held between writes)
//   w_en      out  RAM write strobe, one cycle per word
//   cpu_hold  out  keeps the core in reset during / after a failed load
//   done      out  one-cycle pulse on a good load
//   error     out  one-cycle pulse on oversize length or bad checksum
// -----------------------------------------------------------------------------
module i_ram_loader
  import i_ram_loader_pkg::*;
#(
  parameter int          addr_width = 12,
  parameter logic [7:0]  sync_byte  = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [addr_width-1:0] w_addr,
  output logic [15:0]           din,
  output logic                  w_en,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Largest legal word count; 17 bits so that 1<<16 would still be representable.
  localparam logic [16:0] MAX_WORDS = 17'(1) << addr_width;

  loader_state_t         state_reg;
  logic [7:0]            len_hi_reg;
  logic [15:0]           len_reg;
  logic [7:0]            data_hi_reg;
  logic [7:0]            chk_reg;
  // One bit wider than the address so that a full 1<<addr_width image can be
  // counted to completion.
  logic [addr_width:0]   word_cnt_reg;

  logic                  hs;
  logic [15:0]           len_word;
  logic [7:0]            chk_next;
  logic [addr_width:0]   cnt_inc;

  assign hs       = rx_valid & rx_ready;
  assign len_word = {len_hi_reg, rx_data};
  assign chk_next = chk_reg + rx_data;   // modulo-256 accumulation
  assign cnt_inc  = word_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      len_hi_reg   <= '0;
      len_reg      <= '0;
      data_hi_reg  <= '0;
      chk_reg      <= '0;
      word_cnt_reg <= '0;
      rx_ready     <= 1'b0;
      w_addr       <= '0;
      din          <= '0;
      w_en         <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      // Pulse outputs default low; rx_ready defaults high and is only pulled
      // down when entering FIN.
      w_en     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rx_ready <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (hs && (rx_data == sync_byte)) begin
            state_reg    <= ST_LEN_HI;
            word_cnt_reg <= '0;
            chk_reg      <= '0;
            cpu_hold     <= 1'b1;
          end
        end

        ST_LEN_HI: begin
          if (hs) begin
            len_hi_reg <= rx_data;
            chk_reg    <= chk_next;
            state_reg  <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (hs) begin
            len_reg <= len_word;
            chk_reg <= chk_next;
            if ({1'b0, len_word} > MAX_WORDS) begin
              // cpu_hold is left as is: the core stays held after a bad frame.
              error     <= 1'b1;
              state_reg <= ST_IDLE;
            end else if (len_word == 16'd0) begin
              state_reg <= ST_CHECK;
            end else begin
              state_reg <= ST_DATA_HI;
            end
          end
        end

        ST_DATA_HI: begin
          if (hs) begin
            data_hi_reg <= rx_data;
            chk_reg     <= chk_next;
            state_reg   <= ST_DATA_LO;
          end
        end

        ST_DATA_LO: begin
          if (hs) begin
            w_en         <= 1'b1;
            w_addr       <= word_cnt_reg[addr_width-1:0];
            din          <= {data_hi_reg, rx_data};
            word_cnt_reg <= cnt_inc;
            chk_reg      <= chk_next;
            if (17'(cnt_inc) == {1'b0, len_reg}) begin
              state_reg <= ST_CHECK;
            end else begin
              state_reg <= ST_DATA_HI;
            end
          end
        end

        ST_CHECK: begin
          if (hs) begin
            // Words already written stay in RAM whatever the outcome.
            if (chk_next == 8'h00) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
            chk_reg   <= chk_next;
            state_reg <= ST_FIN;
            rx_ready  <= ready_in_state(ST_FIN);
          end
        end

        ST_FIN: begin
          state_reg <= ST_IDLE;
          rx_ready  <= ready_in_state(ST_IDLE);
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_i_ram_loader
//   Drives framed byte streams (directed cases plus randomized frames) into
//   i_ram_loader and compares every accepted byte's effect against a frame
//   model: which byte is expected to write which word, and which byte ends
//   the frame with done or error.
// -----------------------------------------------------------------------------
module tb_i_ram_loader;

  localparam int AW = 12;
  localparam int MAX_WORDS = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] w_addr;
  logic [15:0]   din;
  logic          w_en;
  logic          cpu_hold;
  logic          done;
  logic          error;

  i_ram_loader #(.addr_width(AW), .sync_byte(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .w_addr   (w_addr),
    .din      (din),
    .w_en     (w_en),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int wen_seen;
  int exp_writes;
  logic exp_hold;

  logic [15:0] words_q[$];
  logic [7:0]  garbage_q[$];

  always @(negedge clk) if (w_en === 1'b1) wen_seen++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one byte after 'gap' idle cycles and returns 1 ns after the
  // clock edge on which it was accepted.
  task automatic xfer(input logic [7:0] b, input int gap);
    int guard;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (rx_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check_val("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_wen"},  {31'd0, w_en},  32'd0);
    check_val({tag, "_done"}, {31'd0, done},  32'd0);
    check_val({tag, "_err"},  {31'd0, error}, 32'd0);
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
  endfunction

  // Sends garbage_q, then a frame with length field 'len', data words_q and
  // checksum = correct value + chk_delta. stall_cycles extra idle cycles are
  // inserted before frame byte stall_idx (sync = 0). When abort_word >= 0 the
  // task returns right after that word's write strobe is checked.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] chk_delta,
                           input int max_gap, input int stall_idx, input int stall_cycles,
                           input int abort_word, output bit aborted);
    logic [7:0] sum;
    logic [7:0] chk;
    logic [7:0] hb;
    logic [7:0] lb;
    int idx;
    bit good;
    aborted = 1'b0;
    sum = 8'd0;
    idx = 0;

    foreach (garbage_q[k]) begin
      xfer(garbage_q[k], pick_gap(max_gap));
      check_quiet("idle_byte");
      check_val("idle_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
    end

    xfer(8'hA5, pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
    idx++;
    exp_hold = 1'b1;
    check_quiet("sync");
    check_val("sync_hold", {31'd0, cpu_hold}, 32'd1);

    xfer(len[15:8], pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
    idx++;
    sum += len[15:8];
    check_quiet("len_hi");

    xfer(len[7:0], pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
    idx++;
    sum += len[7:0];
    if (int'(len) > MAX_WORDS) begin
      check_val("ovs_err",  {31'd0, error},    32'd1);
      check_val("ovs_wen",  {31'd0, w_en},     32'd0);
      check_val("ovs_done", {31'd0, done},     32'd0);
      check_val("ovs_hold", {31'd0, cpu_hold}, 32'd1);
      @(posedge clk); #1;
      check_val("ovs_err_pulse", {31'd0, error},    32'd0);
      check_val("ovs_ready",     {31'd0, rx_ready}, 32'd1);
      $display("frame len=%0h: oversize, error", len);
      return;
    end
    check_quiet("len_lo");

    for (int j = 0; j < words_q.size(); j++) begin
      hb = words_q[j][15:8];
      lb = words_q[j][7:0];
      xfer(hb, pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
      idx++;
      sum += hb;
      check_quiet("data_hi");
      xfer(lb, pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
      idx++;
      sum += lb;
      check_val("wr_en",   {31'd0, w_en},        32'd1);
      check_val("wr_addr", {20'd0, w_addr},      j & (MAX_WORDS - 1));
      check_val("wr_data", {16'd0, din},         {16'd0, words_q[j]});
      check_val("wr_done", {31'd0, done | error}, 32'd0);
      if (j == abort_word) begin
        aborted = 1'b1;
        $display("frame len=%0h: aborted after word %0d", len, j);
        return;
      end
      exp_writes++;
    end

    chk  = 8'(8'd0 - sum) + chk_delta;
    good = ((sum + chk) == 8'd0);
    xfer(chk, pick_gap(max_gap) + ((idx == stall_idx) ? stall_cycles : 0));
    if (good) exp_hold = 1'b0;
    check_val("chk_done",  {31'd0, done},     {31'd0, good});
    check_val("chk_err",   {31'd0, error},    {31'd0, !good});
    check_val("chk_wen",   {31'd0, w_en},     32'd0);
    check_val("fin_ready", {31'd0, rx_ready}, 32'd0);
    check_val("chk_hold",  {31'd0, cpu_hold}, {31'd0, exp_hold});
    @(posedge clk); #1;
    check_val("done_pulse", {31'd0, done},     32'd0);
    check_val("err_pulse",  {31'd0, error},    32'd0);
    check_val("idle_ready", {31'd0, rx_ready}, 32'd1);
    check_val("post_hold",  {31'd0, cpu_hold}, {31'd0, exp_hold});
    $display("frame len=%0h words=%0d chk=%0h: %s", len, words_q.size(), chk, good ? "done" : "error");
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    check_val({tag, "_wen"},   {31'd0, w_en},     32'd0);
    check_val({tag, "_addr"},  {20'd0, w_addr},   32'd0);
    check_val({tag, "_din"},   {16'd0, din},      32'd0);
    check_val({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    check_val({tag, "_done"},  {31'd0, done},     32'd0);
    check_val({tag, "_err"},   {31'd0, error},    32'd0);
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
    exp_hold = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_reset", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    bit ab;
    int n;
    logic [7:0] g;
    n_checks = 0;
    n_fail = 0;
    wen_seen = 0;
    exp_writes = 0;
    exp_hold = 1'b0;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Good frame with a 3-cycle stall before the byte following 0x34.
    garbage_q = {};
    words_q = {16'h1234, 16'hABCD};
    run_frame(16'd2, 8'd0, 0, 5, 3, -1, ab);

    // Leading garbage and empty image.
    garbage_q = {8'h00, 8'hFF};
    words_q = {};
    run_frame(16'd0, 8'd0, 0, -1, 0, -1, ab);

    // Bad checksum (CHK = 0x41), then a good frame releases the hold.
    garbage_q = {};
    words_q = {16'h1234, 16'hABCD};
    run_frame(16'd2, 8'd1, 0, -1, 0, -1, ab);
    run_frame(16'd2, 8'd0, 1, -1, 0, -1, ab);

    // Oversize length 0x1001, followed by a frame to show the parser is idle.
    words_q = {};
    run_frame(16'h1001, 8'd0, 0, -1, 0, -1, ab);
    words_q = {16'h0001};
    run_frame(16'd1, 8'd0, 0, -1, 0, -1, ab);

    // Randomized frames, including mid-frame sync values as data.
    for (int f = 0; f < 24; f++) begin
      garbage_q = {};
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        garbage_q.push_back(g);
      end
      words_q = {};
      if ($urandom_range(0, 7) == 0) begin
        run_frame(16'($urandom_range(MAX_WORDS + 1, 65535)), 8'd0, 2, -1, 0, -1, ab);
      end else begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
        if (n > 0 && $urandom_range(0, 2) == 0) words_q[0] = 16'hA5A5;
        run_frame(16'(n), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                  2, -1, 0, -1, ab);
      end
    end

    // Maximum image.
    garbage_q = {};
    words_q = {};
    for (int k = 0; k < MAX_WORDS; k++) words_q.push_back(16'($urandom));
    run_frame(16'(MAX_WORDS), 8'd0, 0, -1, 0, -1, ab);

    // Reset right after the third write of a five-word frame.
    words_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_frame(16'd5, 8'd0, 0, -1, 0, 2, ab);
    check_val("abort_reached", {31'd0, ab}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    check_reset_outputs("mid_reset_held");
    release_reset();
    words_q = {16'hBEEF, 16'hCAFE};
    run_frame(16'd2, 8'd0, 1, -1, 0, -1, ab);

    repeat (2) @(posedge clk);
    #1;
    check_val("total_writes", wen_seen, exp_writes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
